// File: rtl/perip_flexbus_regfile_if.sv
// -----------------------------------------------------------------------------
// perip_flexbus_regfile_if
// Control strobes of the MCU FlexBus as seen by a PL slave.
//   FB_RW  : 1 = read, 0 = write (meaningful while FB_ALE is high)
//   FB_CS  : active-low chip select, data phase while low
//   FB_ALE : active-high address latch enable
// The multiplexed FB_AD bus is a resolved tri-state net, so it is carried as a
// plain inout port on the slave rather than through this interface.
// -----------------------------------------------------------------------------
interface perip_flexbus_regfile_if;
   logic FB_RW;
   logic FB_CS;
   logic FB_ALE;

   modport master (output FB_RW, output FB_CS, output FB_ALE);
   modport slave  (input  FB_RW, input  FB_CS, input  FB_ALE);
endinterface

// File: rtl/perip_flexbus_regfile.sv
// -----------------------------------------------------------------------------
// perip_flexbus_regfile
// FlexBus slave register file: REG_NUM 32-bit registers in a window at FB_BASE.
// Each register is either writable (held here, reset to its RST_VAL slice) or
// read-only (reads return the REG_Din slice, writes are dropped).
//
// Ports
//   FB_CLK    : FlexBus clock, sole clock
//   RST_n     : asynchronous active-low reset
//   fb        : FlexBus control strobes (FB_RW, FB_CS, FB_ALE)
//   FB_AD     : multiplexed address/data, driven only during a read data phase
//   REG_Din   : read-only register sources, slice i for register i
//   REG_Qout  : writable register contents, slice i (read-only slices are 0)
//   WR_STB    : one-cycle pulse when a write to register i is accepted
//   RD_STB    : one-cycle pulse when read data of register i is latched
//   dbg_state : current bus FSM state (IDLE=0, ADDR=1, DONE=2)
//
// Handshake: FB_ALE high on an edge latches address, direction and decode and
// aborts anything in flight. Afterwards exactly one data beat (FB_CS low,
// FB_ALE low) is accepted, however many cycles FB_CS stays high before it;
// FB_CS high after the beat closes the transaction.
// -----------------------------------------------------------------------------
module perip_flexbus_regfile #(
   parameter logic [31:0]           FB_BASE = 32'h6000_0000,
   parameter int                    REG_NUM = 8,
   parameter logic [REG_NUM-1:0]    RO_MASK = '0,
   parameter logic [REG_NUM*32-1:0] RST_VAL = '0
) (
   input  logic                    FB_CLK,
   input  logic                    RST_n,
   perip_flexbus_regfile_if.slave  fb,
   inout  wire  [31:0]             FB_AD,
   input  logic [REG_NUM*32-1:0]   REG_Din,
   output logic [REG_NUM*32-1:0]   REG_Qout,
   output logic [REG_NUM-1:0]      WR_STB,
   output logic [REG_NUM-1:0]      RD_STB,
   output logic [1:0]              dbg_state
);

   localparam int IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
   localparam int ADDR_W = IDX_W + 2;
   localparam int SLOTS  = 1 << IDX_W;
   // Read-only mask padded to the full index range so any idx can select it.
   localparam logic [SLOTS-1:0] RO_PAD = SLOTS'(RO_MASK);

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DONE = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ad_idx, idx_q;
   logic              ad_hit, hit_q, rw_q;
   logic              rd_launch, wr_fire;
   logic              rd_oe;
   logic [31:0]       rdata;
   logic [SLOTS*32-1:0] rd_src;   // per-slot read source, flattened
   logic [SLOTS-1:0]  rd_oh, wr_oh;
   logic              unused_din;

   // Address decode on the live bus; only used on an ALE edge.
   assign ad_idx = FB_AD[ADDR_W-1:2];
   assign ad_hit = (FB_AD[31:ADDR_W] == FB_BASE[31:ADDR_W]) &&
                   (FB_AD[1:0] == 2'b00) && (int'(ad_idx) < REG_NUM);

   assign rd_launch = fb.FB_ALE && fb.FB_RW && ad_hit;
   assign wr_fire   = (state_q == ADDR) && !fb.FB_ALE && !fb.FB_CS &&
                      !rw_q && hit_q && !RO_PAD[idx_q];

   assign rd_oh = SLOTS'(1) << ad_idx;
   assign wr_oh = SLOTS'(1) << idx_q;

   // Register storage. Read-only slots keep no state; slots beyond REG_NUM
   // only exist so the read mux has a power-of-two range.
   for (genvar i = 0; i < SLOTS; i++) begin : g_reg
      if (i < REG_NUM) begin : g_used
         if (RO_MASK[i]) begin : g_ro
            assign REG_Qout[32*i +: 32] = 32'd0;
            assign rd_src[32*i +: 32]   = REG_Din[32*i +: 32];
         end else begin : g_rw
            logic [31:0] q;
            always_ff @(posedge FB_CLK or negedge RST_n) begin
               if (!RST_n)
                  q <= RST_VAL[32*i +: 32];
               else if (wr_fire && (idx_q == IDX_W'(i)))
                  q <= FB_AD;
            end
            assign REG_Qout[32*i +: 32] = q;
            assign rd_src[32*i +: 32]   = q;
         end
      end else begin : g_pad
         assign rd_src[32*i +: 32] = 32'd0;
      end
   end

   // Writable slices never look at their REG_Din input.
   assign unused_din = ^REG_Din;

   // Next-state logic: ALE wins from every state.
   always_comb begin
      state_d = state_q;
      if (fb.FB_ALE) begin
         state_d = ADDR;
      end else begin
         case (state_q)
            ADDR:    if (!fb.FB_CS) state_d = DONE;
            DONE:    if (fb.FB_CS)  state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge FB_CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         hit_q   <= 1'b0;
         rw_q    <= 1'b0;
         rd_oe   <= 1'b0;
         rdata   <= 32'd0;
         WR_STB  <= '0;
         RD_STB  <= '0;
      end else begin
         state_q <= state_d;
         WR_STB  <= wr_fire   ? REG_NUM'(wr_oh) : '0;
         RD_STB  <= rd_launch ? REG_NUM'(rd_oh) : '0;
         if (fb.FB_ALE) begin
            idx_q <= ad_idx;
            hit_q <= ad_hit;
            rw_q  <= fb.FB_RW;
            rd_oe <= rd_launch;
            if (rd_launch)
               rdata <= rd_src[32*ad_idx +: 32];
         end else if ((state_q == DONE) && fb.FB_CS) begin
            // Data beat has been seen and CS has gone away.
            rd_oe <= 1'b0;
         end
      end
   end

   // Release is purely combinational on CS/ALE: no turnaround cycle.
   assign FB_AD = (rd_oe && !fb.FB_CS && !fb.FB_ALE) ? rdata : 32'bz;

   assign dbg_state = state_q;

endmodule

// File: tb/tb_perip_flexbus_regfile.sv
module tb_perip_flexbus_regfile;

   localparam logic [31:0]  BASE = 32'h6000_0000;
   localparam logic [31:0]  REL  = 32'hFFFF_FFFF;  // undriven bus value via pull-ups
   localparam logic [7:0]   RO8  = 8'h80;
   localparam logic [255:0] RST8 = {32'hA0000007, 32'hA0000006, 32'hA0000005, 32'hA0000004,
                                    32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
   localparam logic [159:0] RST5 = {32'hB0000004, 32'hB0000003, 32'hB0000002,
                                    32'hB0000001, 32'hB0000000};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   perip_flexbus_regfile_if fb8();
   perip_flexbus_regfile_if fb5();

   wire  [31:0] ad8, ad5;
   logic        oe8, oe5;
   logic [31:0] dr8, dr5;
   assign ad8 = oe8 ? dr8 : 32'bz;
   assign ad5 = oe5 ? dr5 : 32'bz;
   for (genvar g = 0; g < 32; g++) begin : g_pu
      pullup (ad8[g]);
      pullup (ad5[g]);
   end

   logic [255:0] din8, q8;
   logic [7:0]   wr8, rd8;
   logic [1:0]   st8, st5;
   logic [159:0] din5, q5;
   logic [4:0]   wr5, rd5;

   perip_flexbus_regfile #(.FB_BASE(BASE), .REG_NUM(8), .RO_MASK(RO8), .RST_VAL(RST8)) dut8 (
      .FB_CLK(clk), .RST_n(rst_n), .fb(fb8.slave), .FB_AD(ad8), .REG_Din(din8),
      .REG_Qout(q8), .WR_STB(wr8), .RD_STB(rd8), .dbg_state(st8));

   perip_flexbus_regfile #(.FB_BASE(BASE), .REG_NUM(5), .RO_MASK(5'h00), .RST_VAL(RST5)) dut5 (
      .FB_CLK(clk), .RST_n(rst_n), .fb(fb5.slave), .FB_AD(ad5), .REG_Din(din5),
      .REG_Qout(q5), .WR_STB(wr5), .RD_STB(rd5), .dbg_state(st5));

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_err    = 0;
   logic [31:0] exp_q[$];
   logic [31:0] m8[8];
   logic [31:0] m5[5];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: window arithmetic on the byte address.
   task automatic model_txn(input int sel, input logic rw, input logic [31:0] addr,
                            input logic [31:0] data, output logic [7:0] e_wr,
                            output logic [7:0] e_rd, output logic [31:0] e_ad);
      int n;
      logic [31:0] off;
      int idx;
      logic hit, ro;
      n    = (sel == 8) ? 8 : 5;
      off  = addr - BASE;
      hit  = (addr >= BASE) && (off < 32'(4 * n)) && (off % 4 == 0);
      idx  = int'(off / 4);
      ro   = (sel == 8) && hit && RO8[idx[2:0]];
      e_wr = 8'h00;
      e_rd = 8'h00;
      e_ad = REL;
      if (hit && !rw && !ro) begin
         e_wr = 8'(1 << idx);
         if (sel == 8) m8[idx] = data; else m5[idx] = data;
      end else if (hit && rw) begin
         e_rd = 8'(1 << idx);
         if (ro)            e_ad = din8[32*idx +: 32];
         else if (sel == 8) e_ad = m8[idx];
         else               e_ad = m5[idx];
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m8[i] = 32'hA000_0000 | 32'(i);
      for (int i = 0; i < 5; i++) m5[i] = 32'hB000_0000 | 32'(i);
   endtask

   task automatic check_regs(input int sel, input string tag);
      if (sel == 8) begin
         for (int i = 0; i < 8; i++)
            check($sformatf("%s q8[%0d]", tag, i), q8[32*i +: 32], RO8[i] ? 32'd0 : m8[i]);
      end else begin
         for (int i = 0; i < 5; i++)
            check($sformatf("%s q5[%0d]", tag, i), q5[32*i +: 32], m5[i]);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input int sel, input logic ale, input logic cs, input logic rw,
                        input logic oe, input logic [31:0] d);
      if (sel == 8) begin
         fb8.FB_ALE = ale; fb8.FB_CS = cs; fb8.FB_RW = rw; oe8 = oe; dr8 = d;
      end else begin
         fb5.FB_ALE = ale; fb5.FB_CS = cs; fb5.FB_RW = rw; oe5 = oe; dr5 = d;
      end
   endtask

   function automatic logic [31:0] ad_now(input int sel);
      return (sel == 8) ? ad8 : ad5;
   endfunction
   function automatic logic [7:0] wr_now(input int sel);
      return (sel == 8) ? wr8 : {3'b000, wr5};
   endfunction
   function automatic logic [7:0] rd_now(input int sel);
      return (sel == 8) ? rd8 : {3'b000, rd5};
   endfunction

   typedef struct {
      logic [7:0]  rd_stb, rd_after, wr_stb, wr_after;
      logic [31:0] ad, ad_rel;
   } obs_t;

   // One complete transaction: ALE, optional CS-high wait, one beat, release.
   task automatic run_txn(input int sel, input logic rw, input logic [31:0] addr,
                          input logic [31:0] data, input int gap, output obs_t o);
      @(negedge clk);
      drive(sel, 1'b1, 1'b1, rw, 1'b1, addr);
      @(posedge clk); #1;
      o.rd_stb = rd_now(sel);
      for (int k = 0; k < gap; k++) begin
         drive(sel, 1'b0, 1'b1, rw, !rw, data);
         @(posedge clk); #1;
      end
      drive(sel, 1'b0, 1'b0, rw, !rw, data);
      #2 o.ad = ad_now(sel);
      @(posedge clk); #1;
      o.wr_stb   = wr_now(sel);
      o.rd_after = rd_now(sel);
      drive(sel, 1'b0, 1'b1, rw, 1'b0, 32'd0);
      #1 o.ad_rel = ad_now(sel);
      @(posedge clk); #1;
      o.wr_after = wr_now(sel);
   endtask

   task automatic check_txn(input string nm, input logic rw, input obs_t o,
                            input logic [7:0] e_wr, input logic [7:0] e_rd,
                            input logic [31:0] e_ad);
      check({nm, " wr_stb"}, 32'(o.wr_stb), 32'(e_wr));
      check({nm, " wr_stb_one_cycle"}, 32'(o.wr_after), 32'd0);
      if (rw) begin
         check({nm, " rd_stb"}, 32'(o.rd_stb), 32'(e_rd));
         check({nm, " rd_stb_one_cycle"}, 32'(o.rd_after), 32'd0);
         check({nm, " ad_data"}, o.ad, e_ad);
      end
      check({nm, " ad_release"}, o.ad_rel, REL);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  exp_wr;
      logic [7:0]  exp_rd;
      logic [31:0] exp_ad;
   } vec_t;

   vec_t tbl[10];

   initial begin
      obs_t o;
      logic [7:0] e_wr, e_rd;
      logic [31:0] e_ad;

      tbl[0] = '{1'b0, 32'h6000_0004, 32'd2000, 8'h02, 8'h00, REL};
      tbl[1] = '{1'b0, 32'h0000_0004, 32'd3000, 8'h00, 8'h00, REL};
      tbl[2] = '{1'b1, 32'h6000_0004, 32'd0,    8'h00, 8'h02, 32'd2000};
      tbl[3] = '{1'b0, 32'h6000_001C, 32'd5,    8'h00, 8'h00, REL};
      tbl[4] = '{1'b1, 32'h6000_001C, 32'd0,    8'h00, 8'h80, 32'hDEADBEEF};
      tbl[5] = '{1'b1, 32'h6000_0008, 32'd0,    8'h00, 8'h04, 32'hA000_0002};
      tbl[6] = '{1'b0, 32'h6000_0020, 32'd77,   8'h00, 8'h00, REL};
      tbl[7] = '{1'b1, 32'h6000_0000, 32'd0,    8'h00, 8'h01, 32'd1000};
      tbl[8] = '{1'b1, 32'h6000_0022, 32'd0,    8'h00, 8'h00, REL};
      tbl[9] = '{1'b0, 32'h6000_001A, 32'd9,    8'h00, 8'h00, REL};

      din8 = {32'hDEADBEEF, 32'h1111_0006, 32'h1111_0005, 32'h1111_0004,
              32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
      din5 = {5{32'h2222_2222}};
      drive(8, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      drive(5, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_regs(8, "reset");
      check_regs(5, "reset");
      check("reset wr8", 32'(wr8), 32'd0);
      check("reset rd8", 32'(rd8), 32'd0);
      check("reset ad8", ad8, REL);
      check("reset state8", 32'(st8), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Write reg0, then a second beat in the same transaction is ignored.
      @(negedge clk);
      drive(8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h6000_0000);
      @(posedge clk); #1;
      drive(8, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1000);
      @(posedge clk); #1;
      model_txn(8, 1'b0, 32'h6000_0000, 32'd1000, e_wr, e_rd, e_ad);
      check("beat1 wr_stb", 32'(wr8), 32'h01);
      check("beat1 reg0", q8[31:0], 32'd1000);
      drive(8, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1001);
      @(posedge clk); #1;
      check("beat2 wr_stb", 32'(wr8), 32'h00);
      check("beat2 reg0", q8[31:0], 32'd1000);
      drive(8, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
      check("done->idle state", 32'(st8), 32'd0);

      // Table of single transactions on the 8-register instance.
      foreach (tbl[i]) begin
         run_txn(8, tbl[i].rw, tbl[i].addr, tbl[i].data, 0, o);
         model_txn(8, tbl[i].rw, tbl[i].addr, tbl[i].data, e_wr, e_rd, e_ad);
         check_txn($sformatf("vec%0d", i), tbl[i].rw, o, tbl[i].exp_wr, tbl[i].exp_rd, tbl[i].exp_ad);
      end
      check_regs(8, "table");

      // ALE during a read data phase: bus released at once, new address taken.
      @(negedge clk);
      drive(8, 1'b1, 1'b1, 1'b1, 1'b1, 32'h6000_0004);
      @(posedge clk); #1;
      drive(8, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      #2 check("abort ad before", ad8, m8[1]);
      drive(8, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      #1 check("abort ad released", ad8, REL);
      drive(8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h6000_0008);
      @(posedge clk); #1;
      drive(8, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4444);
      @(posedge clk); #1;
      model_txn(8, 1'b0, 32'h6000_0008, 32'd4444, e_wr, e_rd, e_ad);
      check("abort new wr_stb", 32'(wr8), 32'(e_wr));
      check("abort new reg2", q8[95:64], 32'd4444);
      drive(8, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;

      // Reset in the middle of a read data phase.
      @(negedge clk);
      drive(8, 1'b1, 1'b1, 1'b1, 1'b1, 32'h6000_0008);
      @(posedge clk); #1;
      drive(8, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      #2 check("midrst ad before", ad8, 32'd4444);
      rst_n = 1'b0;
      #1 check("midrst ad released", ad8, REL);
      model_reset();
      check_regs(8, "midrst");
      check("midrst rd8", 32'(rd8), 32'd0);
      drive(8, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Five-register instance: out-of-range and misaligned are misses.
      run_txn(5, 1'b0, 32'h6000_0014, 32'd11, 0, o);
      check_txn("r5 idx5 wr", 1'b0, o, 8'h00, 8'h00, REL);
      run_txn(5, 1'b0, 32'h6000_0002, 32'd12, 0, o);
      check_txn("r5 misalign wr", 1'b0, o, 8'h00, 8'h00, REL);
      run_txn(5, 1'b1, 32'h6000_0014, 32'd0, 0, o);
      check_txn("r5 idx5 rd", 1'b1, o, 8'h00, 8'h00, REL);
      run_txn(5, 1'b0, 32'h6000_0010, 32'd55, 1, o);
      model_txn(5, 1'b0, 32'h6000_0010, 32'd55, e_wr, e_rd, e_ad);
      check_txn("r5 idx4 wr", 1'b0, o, 8'h10, 8'h00, REL);
      run_txn(5, 1'b1, 32'h6000_0010, 32'd0, 2, o);
      check_txn("r5 idx4 rd", 1'b1, o, 8'h00, 8'h10, 32'd55);
      check_regs(5, "r5");

      // Randomized traffic against the model.
      for (int t = 0; t < 80; t++) begin
         logic rw;
         logic [31:0] addr, data;
         int r, gap;
         rw   = 1'($urandom_range(0, 1));
         r    = $urandom_range(0, 9);
         if (r < 7)       addr = BASE + 32'($urandom_range(0, 9) << 2);
         else if (r == 7) addr = BASE + 32'($urandom_range(0, 39));
         else             addr = $urandom;
         data = $urandom & 32'h7FFF_FFFF;
         gap  = $urandom_range(0, 2);
         model_txn(8, rw, addr, data, e_wr, e_rd, e_ad);
         exp_q.push_back(e_ad);
         run_txn(8, rw, addr, data, gap, o);
         check_txn($sformatf("rand%0d", t), rw, o, e_wr, e_rd, exp_q.pop_front());
      end
      check_regs(8, "rand");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      n_err++;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
